// File: rtl/sensor_frame_pkg.sv
// Shared constants, payload type and frame-length helper for the sensor frame packer.
// Define CHECKSUM_EN to append an XOR checksum byte to every frame.
package sensor_frame_pkg;

  localparam logic [7:0]  HDR_BYTE     = 8'hA5;
  localparam int unsigned SENSOR_BYTES = 15;
  localparam int unsigned COMP_W       = 16;

  localparam int unsigned FLAG_SEEN_Q  = 0;
  localparam int unsigned FLAG_SEEN_G  = 1;
  localparam int unsigned FLAG_STALE_Q = 2;
  localparam int unsigned FLAG_STALE_G = 3;

`ifdef CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  // Field order matches the on-wire byte order (w,x,y,z then gyro x,y,z).
  typedef struct packed {
    logic [COMP_W-1:0] qw;
    logic [COMP_W-1:0] qx;
    logic [COMP_W-1:0] qy;
    logic [COMP_W-1:0] qz;
    logic [COMP_W-1:0] gx;
    logic [COMP_W-1:0] gy;
    logic [COMP_W-1:0] gz;
  } sensor_rec_t;

  localparam int unsigned REC_W = $bits(sensor_rec_t);

  function automatic int unsigned frame_bytes(input int unsigned ns, input bit cks);
    return 3 + SENSOR_BYTES * ns + (cks ? 1 : 0);
  endfunction

  // Byte k of a record, MSB first.
  function automatic logic [7:0] rec_byte(input sensor_rec_t rec, input int unsigned k);
    logic [REC_W-1:0] v;
    v = rec;
    return v[REC_W-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/sensor_age_counter.sv
// Saturating data-age counter; stale is high once LIMIT cycles pass without a hit.
module sensor_age_counter #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit,
  output logic stale
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] age;
  logic [W-1:0] age_nxt;

  always_comb begin
    age_nxt = age;
    if (hit) begin
      age_nxt = '0;
    end else if (age != W'(LIMIT)) begin
      age_nxt = age + W'(1);
    end
  end

  // stale is registered alongside age so it tracks age exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age   <= W'(LIMIT);
      stale <= 1'b1;
    end else begin
      age   <= age_nxt;
      stale <= (age_nxt == W'(LIMIT));
    end
  end

endmodule

// File: rtl/sensor_frame_packer.sv
// Latches N IMU channels and snapshots them into a byte-addressed shadow frame on frame_start.
// Define CHECKSUM_EN to append an XOR checksum byte captured with each snapshot.
module sensor_frame_packer
  import sensor_frame_pkg::*;
#(
  parameter int unsigned NUM_SENSORS  = 2,
  parameter int unsigned NUM_BTNS     = 2,
  parameter int unsigned STALE_CYCLES = 50000,
  localparam int unsigned FRAME_BYTES = frame_bytes(NUM_SENSORS, CKS_EN),
  localparam int unsigned AW          = $clog2(FRAME_BYTES)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SENSORS-1:0]              quat_valid,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  quat_w,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  quat_x,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  quat_y,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  quat_z,
  input  logic [NUM_SENSORS-1:0]              gyro_valid,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  gyro_x,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  gyro_y,
  input  logic [NUM_SENSORS-1:0][COMP_W-1:0]  gyro_z,
  input  logic [NUM_BTNS-1:0]                 btn_n,
  input  logic                                frame_start,
  input  logic [AW-1:0]                       rd_addr,
  output logic [7:0]                          rd_data,
  output logic                                data_ready,
  input  logic                                data_ack,
  output logic [7:0]                          frame_seq
);

  localparam int unsigned BTN_IDX = 2 + SENSOR_BYTES * NUM_SENSORS;

  typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

  sensor_rec_t [NUM_SENSORS-1:0] live_rec;
  logic [NUM_SENSORS-1:0]        seen_q, seen_g, stale_q, stale_g;
  logic [NUM_BTNS-1:0]           btn_meta, btn_sync, pressed;

  // Shadow keeps "fresh" rather than "stale" so an all-zero reset reads back as stale.
  sensor_rec_t [NUM_SENSORS-1:0] sh_rec;
  logic [NUM_SENSORS-1:0]        sh_seen_q, sh_seen_g, sh_fresh_q, sh_fresh_g;
  logic [NUM_BTNS-1:0]           sh_btn;
  frame_t                        sh_frame;

  function automatic frame_t build_frame(
    input sensor_rec_t [NUM_SENSORS-1:0] recs,
    input logic [NUM_SENSORS-1:0]        sq,
    input logic [NUM_SENSORS-1:0]        sg,
    input logic [NUM_SENSORS-1:0]        stq,
    input logic [NUM_SENSORS-1:0]        stg,
    input logic [NUM_BTNS-1:0]           btn,
    input logic [7:0]                    seq
  );
    frame_t     f;
    logic [7:0] flags;
    f    = '0;
    f[0] = HDR_BYTE;
    f[1] = seq;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      for (int unsigned k = 0; k < SENSOR_BYTES - 1; k++) begin
        f[2 + SENSOR_BYTES*i + k] = rec_byte(recs[i], k);
      end
      flags               = '0;
      flags[FLAG_SEEN_Q]  = sq[i];
      flags[FLAG_SEEN_G]  = sg[i];
      flags[FLAG_STALE_Q] = stq[i];
      flags[FLAG_STALE_G] = stg[i];
      f[2 + SENSOR_BYTES*i + SENSOR_BYTES - 1] = flags;
    end
    f[BTN_IDX] = 8'(btn);
    return f;
  endfunction

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_age
    sensor_age_counter #(.LIMIT(STALE_CYCLES)) u_age_q (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (quat_valid[i]),
      .stale (stale_q[i])
    );
    sensor_age_counter #(.LIMIT(STALE_CYCLES)) u_age_g (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (gyro_valid[i]),
      .stale (stale_g[i])
    );
  end

  assign pressed = ~btn_sync;

  // Live channel latches, button synchroniser and data_ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_rec   <= '0;
      seen_q     <= '0;
      seen_g     <= '0;
      btn_meta   <= '0;
      btn_sync   <= '0;
      data_ready <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (quat_valid[i]) begin
          live_rec[i].qw <= quat_w[i];
          live_rec[i].qx <= quat_x[i];
          live_rec[i].qy <= quat_y[i];
          live_rec[i].qz <= quat_z[i];
          seen_q[i]      <= 1'b1;
        end
        if (gyro_valid[i]) begin
          live_rec[i].gx <= gyro_x[i];
          live_rec[i].gy <= gyro_y[i];
          live_rec[i].gz <= gyro_z[i];
          seen_g[i]      <= 1'b1;
        end
      end
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
      if (|quat_valid || |gyro_valid) begin
        data_ready <= 1'b1;
      end else if (data_ack) begin
        data_ready <= 1'b0;
      end
    end
  end

`ifdef CHECKSUM_EN
  frame_t     live_frame;
  logic [7:0] live_cks;
  logic [7:0] sh_cks;

  // The last live byte is always zero, so folding it in leaves the XOR unchanged.
  always_comb begin
    live_frame = build_frame(live_rec, seen_q, seen_g, stale_q, stale_g, pressed,
                             frame_seq + 8'd1);
    live_cks   = '0;
    for (int unsigned b = 0; b < FRAME_BYTES; b++) begin
      live_cks = live_cks ^ live_frame[b];
    end
  end
`endif

  // Snapshot of the live frame; frame_seq names the frame now held in the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_rec     <= '0;
      sh_seen_q  <= '0;
      sh_seen_g  <= '0;
      sh_fresh_q <= '0;
      sh_fresh_g <= '0;
      sh_btn     <= '0;
      frame_seq  <= '0;
`ifdef CHECKSUM_EN
      sh_cks     <= '0;
`endif
    end else if (frame_start) begin
      sh_rec     <= live_rec;
      sh_seen_q  <= seen_q;
      sh_seen_g  <= seen_g;
      sh_fresh_q <= ~stale_q;
      sh_fresh_g <= ~stale_g;
      sh_btn     <= pressed;
      frame_seq  <= frame_seq + 8'd1;
`ifdef CHECKSUM_EN
      sh_cks     <= live_cks;
`endif
    end
  end

  always_comb begin
    sh_frame = build_frame(sh_rec, sh_seen_q, sh_seen_g, ~sh_fresh_q, ~sh_fresh_g, sh_btn,
                           frame_seq);
`ifdef CHECKSUM_EN
    sh_frame[FRAME_BYTES-1] = sh_cks;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < (AW+1)'(FRAME_BYTES)) begin
      rd_data <= sh_frame[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed self-checking bench for sensor_frame_packer (NS=2, NB=2, STALE_CYCLES=4).
module tb_sensor_frame_packer;

  localparam int unsigned NS = 2;
  localparam int unsigned NB = 2;
`ifdef CHECKSUM_EN
  localparam int unsigned FB = 34;
`else
  localparam int unsigned FB = 33;
`endif
  localparam int unsigned AW = 6;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NS-1:0]           quat_valid, gyro_valid;
  logic [NS-1:0][15:0]     quat_w, quat_x, quat_y, quat_z;
  logic [NS-1:0][15:0]     gyro_x, gyro_y, gyro_z;
  logic [NB-1:0]           btn_n;
  logic                    frame_start;
  logic [AW-1:0]           rd_addr;
  logic [7:0]              rd_data;
  logic                    data_ready;
  logic                    data_ack;
  logic [7:0]              frame_seq;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned seq      = 0;
  logic [7:0]  v;
  logic [7:0]  acc;
  logic [7:0]  exp_f [FB];

  sensor_frame_packer #(
    .NUM_SENSORS  (NS),
    .NUM_BTNS     (NB),
    .STALE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .quat_valid  (quat_valid),
    .quat_w      (quat_w),
    .quat_x      (quat_x),
    .quat_y      (quat_y),
    .quat_z      (quat_z),
    .gyro_valid  (gyro_valid),
    .gyro_x      (gyro_x),
    .gyro_y      (gyro_y),
    .gyro_z      (gyro_z),
    .btn_n       (btn_n),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .data_ready  (data_ready),
    .data_ack    (data_ack),
    .frame_seq   (frame_seq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int unsigned a, output logic [7:0] d);
    rd_addr = AW'(a);
    tick();
    d = rd_data;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    seq++;
  endtask

  initial begin
    rst_n = 1'b0;
    quat_valid = '0; gyro_valid = '0;
    quat_w = '0; quat_x = '0; quat_y = '0; quat_z = '0;
    gyro_x = '0; gyro_y = '0; gyro_z = '0;
    btn_n = '1; frame_start = 1'b0; rd_addr = '0; data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_data", 32'(rd_data), 32'h0);
    check_eq("rst_ready", 32'(data_ready), 32'h0);
    check_eq("rst_seq", 32'(frame_seq), 32'h0);
    rst_n = 1'b1;
    tick();

    // Empty frame after reset: header, seq 0, both channels unseen and stale.
    for (int a = 0; a < int'(FB); a++) exp_f[a] = 8'h00;
    exp_f[0] = 8'hA5; exp_f[16] = 8'h0C; exp_f[31] = 8'h0C;
    for (int a = 0; a < int'(FB); a++) begin
      rd(a, v);
      check_eq($sformatf("rst_b%0d", a), 32'(v), 32'(exp_f[a]));
    end

    // Channel 1 quaternion followed by a snapshot.
    quat_valid[1] = 1'b1; quat_w[1] = 16'h8001;
    tick();
    quat_valid = '0;
    pulse_frame();
    check_eq("f1_seq", 32'(frame_seq), 32'h01);
    check_eq("f1_ready", 32'(data_ready), 32'h1);
    rd(1, v);  check_eq("f1_b1", 32'(v), 32'h01);
    rd(17, v); check_eq("f1_w_hi", 32'(v), 32'h80);
    rd(18, v); check_eq("f1_w_lo", 32'(v), 32'h01);
    rd(31, v); check_eq("f1_flags1", 32'(v), 32'h09);
    rd(16, v); check_eq("f1_flags0", 32'(v), 32'h0C);

    // data_ready: ack clears, valid beats a simultaneous ack.
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check_eq("ack_clear", 32'(data_ready), 32'h0);
    gyro_valid[0] = 1'b1; gyro_x[0] = 16'h1234; gyro_z[0] = 16'h5678; data_ack = 1'b1;
    tick();
    gyro_valid = '0;
    check_eq("valid_wins", 32'(data_ready), 32'h1);
    tick();
    data_ack = 1'b0;
    check_eq("ack_alone", 32'(data_ready), 32'h0);

    // Valid in the snapshot cycle lands in the following frame; read returns old byte.
    quat_valid[0] = 1'b1; quat_w[0] = 16'hBEEF; rd_addr = AW'(1);
    pulse_frame();
    quat_valid = '0;
    check_eq("rd_old_shadow", 32'(rd_data), 32'h01);
    check_eq("f2_seq", 32'(frame_seq), 32'h02);
    rd(2, v);  check_eq("f2_w_hi_absent", 32'(v), 32'h00);
    rd(3, v);  check_eq("f2_w_lo_absent", 32'(v), 32'h00);
    rd(10, v); check_eq("f2_gx_hi", 32'(v), 32'h12);
    rd(11, v); check_eq("f2_gx_lo", 32'(v), 32'h34);
    rd(14, v); check_eq("f2_gz_hi", 32'(v), 32'h56);
    rd(15, v); check_eq("f2_gz_lo", 32'(v), 32'h78);
    pulse_frame();
    rd(2, v);  check_eq("f3_w_hi", 32'(v), 32'hBE);
    rd(3, v);  check_eq("f3_w_lo", 32'(v), 32'hEF);

    // Stale boundary: k idle cycles after a valid, then snapshot.
    for (int k = 3; k <= 4; k++) begin
      quat_valid[0] = 1'b1; quat_w[0] = 16'h0102;
      tick();
      quat_valid = '0;
      repeat (k) tick();
      pulse_frame();
      rd(16, v);
      check_eq($sformatf("stale_k%0d", k), 32'(v), (k == 4) ? 32'h0F : 32'h0B);
    end
    rd(31, v); check_eq("ch1_stale_flags", 32'(v), 32'h0D);

    // Button 0 pressed, through the synchroniser.
    btn_n = 2'b10;
    repeat (3) tick();
    pulse_frame();
    rd(32, v); check_eq("btn_byte", 32'(v), 32'h01);
    btn_n = 2'b11;
    repeat (3) tick();

    // Back-to-back snapshots up to the sequence wrap.
    frame_start = 1'b1;
    while (seq < 255) begin
      tick();
      seq++;
    end
    check_eq("seq_ff", 32'(frame_seq), 32'hFF);
    tick();
    frame_start = 1'b0;
    check_eq("seq_wrap", 32'(frame_seq), 32'h00);
    rd(1, v); check_eq("wrap_b1", 32'(v), 32'h00);
`ifdef CHECKSUM_EN
    acc = 8'h00;
    for (int a = 0; a < int'(FB); a++) begin
      rd(a, v);
      acc = acc ^ v;
    end
    check_eq("cks_xor", 32'(acc), 32'h00);
`else
    rd(32, v); check_eq("btn_released", 32'(v), 32'h00);
`endif
    rd(FB, v); check_eq("addr_oob", 32'(v), 32'h00);
    rd(63, v); check_eq("addr_max", 32'(v), 32'h00);

    // Reset mid-transfer.
    rd_addr = AW'(0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_rd", 32'(rd_data), 32'h00);
    check_eq("midrst_seq", 32'(frame_seq), 32'h00);
    #5 rst_n = 1'b1;
    tick();
    rd(16, v); check_eq("midrst_flags", 32'(v), 32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
